// File: rtl/cut_agc_pkg.sv
// Shared types and helpers for the DBF cut_ctl AGC: gain-index/cut mapping and the stage-2 sample record.
// Latency: n/a (declarations only); backpressure: n/a.
package cut_agc_pkg;

  localparam int         LEAD_W     = 5;
  localparam logic [2:0] CUT_BYPASS = 3'd7;

  typedef struct packed {
    logic              vld;
    logic              last;
    logic              sat;
    logic [LEAD_W-1:0] lead;
  } lead_smp_t;

  // g=0 is the widest window (no truncation); g=k>0 selects cut k-1.
  function automatic logic [2:0] g_to_cut(input logic [2:0] g);
    return (g == 3'd0) ? CUT_BYPASS : g - 3'd1;
  endfunction

  function automatic logic [2:0] cut_to_g(input logic [2:0] cut);
    return (cut == CUT_BYPASS) ? 3'd0 : cut + 3'd1;
  endfunction

endpackage

// File: rtl/cut_ctl_agc_dbf_if.sv
// I/Q observation stream, manual override and published AGC result for cut_ctl_agc_dbf.
// Latency: n/a (wiring only); backpressure: none, the stream is observe-only.
interface cut_ctl_agc_dbf_if #(
  parameter int LEN = 32
);
  import cut_agc_pkg::*;

  logic [LEN-1:0]    data_i;
  logic [LEN-1:0]    data_q;
  logic              in_valid;
  logic              manual_en;
  logic [2:0]        manual_cut;
  logic [2:0]        cut_ctl;
  logic              cut_valid;
  logic [LEAD_W-1:0] peak_lead;
  logic [15:0]       sat_cnt;

  modport master (
    output data_i, data_q, in_valid, manual_en, manual_cut,
    input  cut_ctl, cut_valid, peak_lead, sat_cnt
  );

  modport slave (
    input  data_i, data_q, in_valid, manual_en, manual_cut,
    output cut_ctl, cut_valid, peak_lead, sat_cnt
  );

endinterface

// File: rtl/lead_sign_cnt.sv
// Counts sign-bit copies directly below the MSB (0..LEN-1) of a two's complement word.
// Latency: combinational; backpressure: none.
module lead_sign_cnt
  import cut_agc_pkg::*;
#(
  parameter int LEN = 32
) (
  input  logic [LEN-1:0]    data,
  output logic [LEAD_W-1:0] lead
);

  // Ascending scan: the last mismatch found is the one nearest the MSB.
  always_comb begin
    lead = LEAD_W'(LEN - 1);
    for (int i = 0; i < LEN - 1; i++) begin
      if (data[i] != data[LEN-1]) begin
        lead = LEAD_W'(LEN - 2 - i);
      end
    end
  end

endmodule

// File: rtl/cut_ctl_agc_dbf.sv
// Closed-loop AGC choosing the DBF truncation window from per-frame peak sign headroom.
// Latency: last frame sample to cut_valid is 3 clocks; backpressure: none, every in_valid sample is consumed.
module cut_ctl_agc_dbf
  import cut_agc_pkg::*;
#(
  parameter int LEN       = 32,
  parameter int FRAME_LEN = 1024,
  parameter int HEADROOM  = 1,
  parameter int CNT_W     = $clog2(FRAME_LEN)
) (
  input logic              clk,
  input logic              rst_n,
  cut_ctl_agc_dbf_if.slave bus
);

  localparam logic [LEAD_W-1:0] LEAD_MAX = LEAD_W'(LEN - 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(FRAME_LEN - 1);

  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [LEN-1:0]    di_q, di_d, dq_q, dq_d;
  logic              v1_q, v1_d, last1_q, last1_d;
  logic [LEAD_W-1:0] lead_i, lead_q;
  lead_smp_t         s2_q, s2_d;
  logic [LEAD_W-1:0] min_q, min_d, res_min_q, res_min_d, peak_q, peak_d;
  logic [15:0]       sacc_q, sacc_d, res_sat_q, res_sat_d, satc_q, satc_d;
  logic              res_vld_q, res_vld_d, vld_q, vld_d;
  logic [2:0]        g_q, g_d, gt, cut_now;
  logic [LEAD_W-1:0] fold_min;
  logic [15:0]       fold_sat;
  int                gt_diff;

  assign cut_now = g_to_cut(g_q);

  lead_sign_cnt #(.LEN(LEN)) u_lead_i (.data(di_q), .lead(lead_i));
  lead_sign_cnt #(.LEN(LEN)) u_lead_q (.data(dq_q), .lead(lead_q));

  always_comb begin : s1_s2_comb
    cnt_d = cnt_q;
    if (bus.in_valid) begin
      cnt_d = (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
    end
    di_d    = bus.data_i;
    dq_d    = bus.data_q;
    v1_d    = bus.in_valid;
    last1_d = bus.in_valid && (cnt_q == CNT_LAST);

    // Saturation is judged against the window in force when the sample reaches this stage.
    s2_d.vld  = v1_q;
    s2_d.last = last1_q;
    s2_d.lead = (lead_i < lead_q) ? lead_i : lead_q;
    s2_d.sat  = (cut_now != CUT_BYPASS) &&
                ((lead_i <= LEAD_W'(cut_now)) || (lead_q <= LEAD_W'(cut_now)));
  end

  always_comb begin : s3_comb
    fold_min  = (s2_q.lead < min_q) ? s2_q.lead : min_q;
    fold_sat  = (!s2_q.sat || sacc_q == 16'hFFFF) ? sacc_q : sacc_q + 16'd1;
    min_d     = min_q;
    sacc_d    = sacc_q;
    res_vld_d = 1'b0;
    res_min_d = res_min_q;
    res_sat_d = res_sat_q;
    if (s2_q.vld) begin
      if (s2_q.last) begin
        res_vld_d = 1'b1;
        res_min_d = fold_min;
        res_sat_d = fold_sat;
        min_d     = LEAD_MAX;
        sacc_d    = '0;
      end else begin
        min_d  = fold_min;
        sacc_d = fold_sat;
      end
    end
  end

  always_comb begin : gain_comb
    gt_diff = int'(res_min_q) - HEADROOM;
    if (gt_diff <= 0) begin
      gt = 3'd0;
    end else if (gt_diff >= 7) begin
      gt = 3'd7;
    end else begin
      gt = 3'(gt_diff);
    end

    g_d    = g_q;
    vld_d  = res_vld_q;
    peak_d = peak_q;
    satc_d = satc_q;
    if (res_vld_q) begin
      peak_d = res_min_q;
      satc_d = res_sat_q;
      if (gt < g_q) begin
        g_d = gt;
      end else if (gt > g_q) begin
        g_d = g_q + 3'd1;
      end
    end
    // Manual override also reseeds g so release continues from the manual window.
    if (bus.manual_en) begin
      g_d = cut_to_g(bus.manual_cut);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      di_q      <= '0;
      dq_q      <= '0;
      v1_q      <= 1'b0;
      last1_q   <= 1'b0;
      s2_q      <= '0;
      min_q     <= LEAD_MAX;
      sacc_q    <= '0;
      res_vld_q <= 1'b0;
      res_min_q <= '0;
      res_sat_q <= '0;
      g_q       <= 3'd0;
      vld_q     <= 1'b0;
      peak_q    <= '0;
      satc_q    <= '0;
    end else begin
      cnt_q     <= cnt_d;
      di_q      <= di_d;
      dq_q      <= dq_d;
      v1_q      <= v1_d;
      last1_q   <= last1_d;
      s2_q      <= s2_d;
      min_q     <= min_d;
      sacc_q    <= sacc_d;
      res_vld_q <= res_vld_d;
      res_min_q <= res_min_d;
      res_sat_q <= res_sat_d;
      g_q       <= g_d;
      vld_q     <= vld_d;
      peak_q    <= peak_d;
      satc_q    <= satc_d;
    end
  end

  assign bus.cut_ctl   = cut_now;
  assign bus.cut_valid = vld_q;
  assign bus.peak_lead = peak_q;
  assign bus.sat_cnt   = satc_q;

endmodule

// File: doc/cut_ctl_agc_dbf.md
Name: cut_ctl_agc_dbf

Overview:
- Closed-loop gain controller that generates the 3-bit cut_ctl word consumed by the DBF truncation/saturation stage (cut_ctl_top_dbf).
- Observes the same 32-bit I/Q stream that enters the truncation stage and measures the peak magnitude over a frame as a minimum count of redundant sign bits.
- At each frame end, selects the truncation window that keeps HEADROOM spare bits, with fast attack and one-step-per-frame release.
- Also reports the number of samples in the frame that saturated under the window in force.

Parameters:
- LEN, 32, I/Q sample width in bits (at least 24).
- FRAME_LEN, 1024, valid samples per measurement frame (at least 2).
- HEADROOM, 1, spare sign bits kept above the frame peak.
- CNT_W, clog2(FRAME_LEN), derived width of the frame counter.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- data_i  in  LEN  I sample, two's complement.
- data_q  in  LEN  Q sample, two's complement.
- in_valid  in  1  sample qualifier.
- manual_en  in  1  1 = bypass AGC and drive manual_cut.
- manual_cut  in  3  cut_ctl value used in manual mode.
- cut_ctl  out  3  truncation select for the DBF truncation stage.
- cut_valid  out  1  one-cycle pulse when a frame result is published.
- peak_lead  out  5  minimum redundant-sign count of the last frame.
- sat_cnt  out  16  samples (I or Q) saturated under the applied cut_ctl in the last frame; saturates at 0xFFFF.

Behaviour:
- Reset:
  - Asynchronous assert, synchronous release on clk.
  - Outputs: cut_ctl=7, cut_valid=0, peak_lead=0, sat_cnt=0.
  - Internal state: gain index g=0, frame counter=0, running minimum = LEN-1, running saturation count=0, pipeline valids=0.
  - Reset mid-frame discards the partial frame.
- Gain index g (0..7):
  - cut_ctl = 7 when g=0, otherwise g-1.
  - cut value c in 0..6 passes a sample unsaturated iff r >= c+1. cut 7 never saturates.
- Redundant-sign count r: number of consecutive bits directly below the MSB that equal the MSB, range 0..LEN-1.
  - 0 and all-ones → LEN-1.
  - 0x80000000 and 0x40000000 → 0.
- Pipeline (only in_valid samples are counted; gaps are allowed):
  - S1 registers data_i, data_q, in_valid, and the frame-last flag (counter == FRAME_LEN-1).
  - S2 registers rI, rQ, r = min(rI, rQ), and sat = (rI < c+1) OR (rQ < c+1) using the current cut_ctl. c=7 gives sat=0.
  - S3 folds r into the running minimum and sat into the running count.
  - On a frame-last sample the folded result is latched instead, and the accumulators reload to LEN-1 / 0 on the same edge.
  - Latency: last valid sample sampled at edge T → cut_ctl, peak_lead, sat_cnt updated and cut_valid high for exactly one cycle at edge T+3.
  - A new frame's samples accumulate back-to-back with no lost cycles.
- Frame counter: increments on in_valid and wraps from FRAME_LEN-1 to 0.
- Update at frame end:
  - gt = clamp(min_r - HEADROOM, 0, 7).
  - gt < g → g = gt (attack, immediate).
  - gt > g → g = g+1 (release, one step).
  - Equal → hold.
- Manual mode (manual_en=1):
  - cut_ctl <= manual_cut on every clock (1-cycle latency).
  - g <= (manual_cut==7 ? 0 : manual_cut+1), so release resumes from the manual value.
  - Measurement, peak_lead, sat_cnt, and cut_valid continue unchanged.
  - manual_en deasserting takes effect at the next frame end.
- cut_ctl changes only at a cut_valid pulse, or during manual mode.

Decomposition:
- Package cut_agc_pkg: function mapping g to cut_ctl and its inverse; constant CUT_BYPASS=3'd7; LEAD_W=5.
- One sub-module: lead_sign_cnt. Combinational priority encoder (LEN in, r out), instantiated twice (I and Q).

Test Plan (LEN=32, FRAME_LEN=8, HEADROOM=1):
1. Reset → cut_ctl=7, cut_valid=0, sat_cnt=0. Assert rst_n=0 mid-frame (3 samples in), release, then send 8 samples → exactly one cut_valid, 3 cycles after the 8th.
2. Frames of I=Q=0x00001234 (r=18):
   - First frame end → peak_lead=18, cut_ctl=0.
   - Each later frame steps release by one; after 7 frames cut_ctl=6; the 8th frame holds 6; sat_cnt=0 throughout.
3. From cut_ctl=6, a frame with one sample I=0x40000000 (r=0), the rest 0x00001234 → peak_lead=0, cut_ctl=7 at that frame end, sat_cnt=1.
4. From cut_ctl=6, a frame with Q=0xF8000000 (r=4) in one sample → gt=3, cut_ctl=2, sat_cnt=1.
5. in_valid toggling 1010… → frame ends only after 8 valid samples; cut_valid is 3 cycles after the 8th valid sample.
6. manual_en=1, manual_cut=4 → cut_ctl=4 one cycle later and holds through frames with r=0. Deassert manual_en, then a frame with r=18 → cut_ctl=5.
